// File: rtl/seg7_capture.sv
// seg7_capture: recovers the 16-bit value shown on a multiplexed 4-digit
// 7-segment display by watching its segment and digit-select lines.
// Inputs are synchronized, debounced by a stability counter, decoded per
// digit into a shadow frame, and published once every digit has been seen.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  dig_sel_i,
  input  logic        err_clr_i,
  output logic [15:0] value_o,
  output logic        valid_o,
  output logic [3:0]  digit_err_o,
  output logic        err_o
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

  // {dig_sel, seg} travel together so a pair is always judged as one word
  logic [10:0] s1;
  logic [10:0] s2;
  logic [10:0] s3;
  logic [7:0]  stable_cnt;
  logic [3:0]  captured;
  logic [15:0] shadow;

  logic        accept;
  logic [3:0]  sel;
  logic [6:0]  pattern;
  logic        one_sel;
  logic [1:0]  slot;
  logic [4:0]  decoded;
  logic [3:0]  cap_en;
  logic [3:0]  err_set;

  // Returns {known, nibble}; known is 0 for any pattern outside the hex font
  function automatic logic [4:0] decode7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer plus one history stage; reset looks like a blank display
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= {dig_sel_i, seg_i};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Count consecutive cycles the synchronized pair has not changed, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stable_cnt <= 8'd0;
    end else if (s2 != s3) begin
      stable_cnt <= 8'd0;
    end else if (stable_cnt != CNT_MAX) begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // Accept is the single cycle the counter steps onto its limit; saturation
  // keeps it from firing again until the pair changes
  always_comb begin
    accept  = (s2 == s3) && (stable_cnt == CNT_PRE);
    sel     = s2[10:7];
    pattern = s2[6:0];
    decoded = decode7(pattern);
    one_sel = 1'b1;
    slot    = 2'd0;
    case (sel)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_sel = 1'b0;
    endcase
    cap_en  = 4'b0000;
    err_set = 4'b0000;
    if (accept && one_sel) begin
      if (decoded[4]) begin
        cap_en = 4'b0001 << slot;
      end else begin
        err_set = 4'b0001 << slot;
      end
    end
  end

  // Collect digits into the shadow frame and publish it once all four are in
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      captured <= 4'b0000;
      shadow   <= 16'h0000;
      value_o  <= 16'h0000;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (captured == 4'b1111) begin
        value_o <= shadow;
        valid_o <= 1'b1;
      end
      captured <= ((captured == 4'b1111) ? 4'b0000 : captured) | cap_en;
      for (int k = 0; k < 4; k++) begin
        if (cap_en[k]) begin
          shadow[4*k +: 4] <= decoded[3:0];
        end
      end
    end
  end

  // Sticky per-digit error flags; a fresh error beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      digit_err_o <= 4'b0000;
    end else begin
      digit_err_o <= (err_clr_i ? 4'b0000 : digit_err_o) | err_set;
    end
  end

  assign err_o = |digit_err_o;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed vector table, hand-written timing/reset
// sequences and a randomized phase, all compared every cycle against a
// behavioural model of the display capture.
module tb_seg7_capture;

  localparam int S = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        err_clr;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_err;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        clr;
    int          hold;
    logic [15:0] exp_value;
    logic [3:0]  exp_err;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[$];

  // Hex font of the display, index = nibble
  logic [6:0] seg_table [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Behavioural model state
  logic [15:0] m_value;
  logic        m_valid;
  logic [3:0]  m_err;
  logic [3:0]  m_capt;
  logic [3:0]  m_shadow [4];
  logic [10:0] prev_sample;
  int          run_len;
  logic [10:0] dec_val [2];
  logic        dec_v   [2];

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .seg_i       (seg),
    .dig_sel_i   (dig_sel),
    .err_clr_i   (err_clr),
    .value_o     (value),
    .valid_o     (valid),
    .digit_err_o (digit_err),
    .err_o       (err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one input pair for hold cycles, counting valid pulses seen
  task automatic applyStimulus(input logic [3:0] s, input logic [6:0] p, input logic c,
                               input int hold, output int pulses);
    pulses  = 0;
    dig_sel = s;
    seg     = p;
    err_clr = c;
    repeat (hold) begin
      @(negedge clk);
      if (valid) pulses++;
    end
  endtask

  task automatic addVec(input logic [3:0] s, input logic [6:0] p, input logic c, input int hold,
                        input logic [15:0] ev, input logic [3:0] ee, input int ep);
    vec_t v;
    v.sel = s; v.seg = p; v.clr = c; v.hold = hold;
    v.exp_value = ev; v.exp_err = ee; v.exp_pulses = ep;
    vecs.push_back(v);
  endtask

  task automatic runVecs(input int first, input int last);
    int pulses;
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].seg, vecs[i].clr, vecs[i].hold, pulses);
      checkOutput($sformatf("vec%0d_value", i), 32'(value), 32'(vecs[i].exp_value));
      checkOutput($sformatf("vec%0d_err", i), 32'(digit_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
    end
  endtask

  // Model: a pair is accepted once it has been sampled S+1 times in a row,
  // and the accept takes effect two edges later (synchronizer delay)
  initial begin
    logic [10:0] eff;
    logic        eff_v;
    logic [10:0] sample;
    logic [3:0]  new_err;
    logic [3:0]  next_capt;
    int          zeros;
    int          slot;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_value = '0; m_valid = 1'b0; m_err = '0; m_capt = '0;
        for (int k = 0; k < 4; k++) m_shadow[k] = '0;
        prev_sample = '1;
        run_len = 3;
        dec_v[0] = 1'b0; dec_v[1] = 1'b0;
        dec_val[0] = '1; dec_val[1] = '1;
      end else begin
        eff_v = dec_v[1];
        eff   = dec_val[1];
        new_err = '0;
        next_capt = m_capt;
        m_valid = 1'b0;
        if (m_capt == 4'hF) begin
          for (int k = 0; k < 4; k++) m_value[4*k +: 4] = m_shadow[k];
          m_valid = 1'b1;
          next_capt = '0;
        end
        if (eff_v) begin
          zeros = 0;
          slot = 0;
          for (int k = 0; k < 4; k++) if (!eff[7+k]) begin zeros++; slot = k; end
          if (zeros == 1) begin
            int found;
            found = -1;
            for (int n = 0; n < 16; n++) if (seg_table[n] == eff[6:0]) found = n;
            if (found >= 0) begin
              m_shadow[slot] = 4'(found);
              next_capt[slot] = 1'b1;
            end else begin
              new_err[slot] = 1'b1;
            end
          end
        end
        m_capt = next_capt;
        m_err = (err_clr ? 4'h0 : m_err) | new_err;
        sample = {dig_sel, seg};
        if (sample == prev_sample) begin
          if (run_len < 1000) run_len++;
        end else begin
          run_len = 1;
        end
        prev_sample = sample;
        dec_v[1] = dec_v[0];
        dec_val[1] = dec_val[0];
        dec_v[0] = (run_len == S + 1);
        dec_val[0] = sample;
      end
    end
  end

  // Compare DUT against the model shortly after every falling edge
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      checkOutput("model_value", 32'(value), 32'(m_value));
      checkOutput("model_valid", 32'(valid), 32'(m_valid));
      checkOutput("model_digit_err", 32'(digit_err), 32'(m_err));
      checkOutput("model_err_or", 32'(err), 32'(|m_err));
      if (prev_valid) checkOutput("valid_twice", 32'(valid), 32'd0);
      prev_valid = valid;
    end
  end

  // Main test sequence
  initial begin
    int pulses;
    logic [3:0] rsel;
    logic [6:0] rseg;
    logic rclr;
    int r;

    rst_n = 1'b0;
    dig_sel = 4'hF;
    seg = 7'h7F;
    err_clr = 1'b0;

    // Frame 1..4 then blank, error, clear, short hold, two-low and blank selects
    addVec(4'b1110, 7'b1111001, 1'b0, 10, 16'h0000, 4'h0, 0);
    addVec(4'b1101, 7'b0100100, 1'b0, 10, 16'h0000, 4'h0, 0);
    addVec(4'b1011, 7'b0110000, 1'b0, 10, 16'h0000, 4'h0, 0);
    addVec(4'b0111, 7'b0011001, 1'b0, 10, 16'h4321, 4'h0, 1);
    addVec(4'b1111, 7'b1111111, 1'b0, 10, 16'h4321, 4'h0, 0);
    addVec(4'b1011, 7'b1111111, 1'b0, 10, 16'h4321, 4'b0100, 0);
    addVec(4'b1111, 7'b1111111, 1'b1, 1,  16'h4321, 4'h0, 0);
    addVec(4'b1101, 7'b1111000, 1'b0, 3,  16'h4321, 4'h0, 0);
    addVec(4'b1101, 7'b0001000, 1'b0, 10, 16'h4321, 4'h0, 0);
    addVec(4'b1110, 7'b1000000, 1'b0, 10, 16'h4321, 4'h0, 0);
    addVec(4'b1011, 7'b0010010, 1'b0, 10, 16'h4321, 4'h0, 0);
    addVec(4'b0111, 7'b1111000, 1'b0, 3,  16'h4321, 4'h0, 0);
    addVec(4'b1111, 7'b1111111, 1'b0, 3,  16'h4321, 4'h0, 0);
    addVec(4'b0111, 7'b0001110, 1'b0, 10, 16'hF5A0, 4'h0, 1);
    addVec(4'b0011, 7'b0000000, 1'b0, 20, 16'hF5A0, 4'h0, 0);
    addVec(4'b1111, 7'b0000000, 1'b0, 20, 16'hF5A0, 4'h0, 0);
    addVec(4'b1110, 7'b0000000, 1'b0, 10, 16'hF5A0, 4'h0, 0);
    addVec(4'b1101, 7'b0000000, 1'b0, 10, 16'hF5A0, 4'h0, 0);
    addVec(4'b1011, 7'b0000000, 1'b0, 10, 16'hF5A0, 4'h0, 0);
    addVec(4'b1110, 7'b1111001, 1'b0, 10, 16'h8888, 4'h0, 0);
    addVec(4'b1101, 7'b1111001, 1'b0, 10, 16'h8888, 4'h0, 0);
    addVec(4'b1011, 7'b1111001, 1'b0, 10, 16'h8888, 4'h0, 0);

    repeat (3) @(negedge clk);
    checkOutput("reset_value", 32'(value), 32'h0);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_err", 32'(digit_err), 32'h0);
    checkOutput("reset_err_or", 32'(err), 32'h0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_accept_after_release", 32'(value), 32'h0);

    runVecs(0, 18);

    // Final digit of a frame of eights: valid exactly after edge S+4
    dig_sel = 4'b0111;
    seg = 7'b0000000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("eights_valid_edge%0d", k), 32'(valid), (k == S + 4) ? 32'd1 : 32'd0);
    end
    checkOutput("eights_value", 32'(value), 32'h8888);

    // Partial frame wiped by reset; digit 3 alone must not complete a frame
    runVecs(19, 21);
    rst_n = 1'b0;
    dig_sel = 4'hF;
    seg = 7'h7F;
    repeat (2) @(negedge clk);
    checkOutput("midreset_value", 32'(value), 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'b0111, 7'b1111001, 1'b0, 20, pulses);
    checkOutput("midreset_pulses", 32'(pulses), 32'd0);
    checkOutput("midreset_value_after", 32'(value), 32'h0);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 70) rsel = ~(4'b0001 << $urandom_range(0, 3));
        else if (r < 85) rsel = 4'hF;
        else rsel = 4'($urandom);
        if ($urandom_range(0, 99) < 75) rseg = seg_table[$urandom_range(0, 15)];
        else rseg = 7'($urandom);
        rclr = ($urandom_range(0, 9) == 0);
        applyStimulus(rsel, rseg, rclr, $urandom_range(1, 10), pulses);
      end
    end

    err_clr = 1'b0;
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
